// File: rtl/alu16_pipe.sv
// Two-stage pipelined Hack ALU with a valid/ready handshake on both sides.
// S1 presets the operands. S2 computes the result, applies the output negate, and registers the flags.

module not16 (
   input  logic [15:0] a,
   output logic [15:0] y
);
   assign y = ~a;
endmodule

module alu16_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] out,
   output logic        zr,
   output logic        ng,
   output logic        out_valid,
   input  logic        out_ready
);
   logic        s1_valid;
   logic [15:0] x1, y1;
   logic        f1, no1;
   logic        s1_adv, s2_adv;
   logic [15:0] xz, xn, xp;
   logic [15:0] yz, yn, yp;
   logic [15:0] r, rn, res;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   assign xz = zx ? 16'h0000 : x;
   assign yz = zy ? 16'h0000 : y;

   not16 u_nx (.a(xz), .y(xn));
   not16 u_ny (.a(yz), .y(yn));

   assign xp = nx ? xn : xz;
   assign yp = ny ? yn : yz;

   // When S1 advances, in_ready is high, so in_valid alone means accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         x1       <= 16'h0000;
         y1       <= 16'h0000;
         f1       <= 1'b0;
         no1      <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            x1  <= xp;
            y1  <= yp;
            f1  <= f;
            no1 <= no;
         end
      end
   end

   assign r = f1 ? (x1 + y1) : (x1 & y1);

   not16 u_no (.a(r), .y(rn));

   assign res = no1 ? rn : r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= 16'h0000;
         zr        <= 1'b0;
         ng        <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out <= res;
            zr  <= (res == 16'h0000);
            ng  <= res[15];
         end
      end
   end
endmodule

// File: tb/tb_alu16_pipe.sv
// Directed self-checking bench for alu16_pipe.
// It covers reset, the ALU functions, latency, stall, streaming and asynchronous reset.

module tb_alu16_pipe;
   logic        clk;
   logic        rst_n;
   logic [15:0] x, y;
   logic        zx, nx, zy, ny, f, no;
   logic        in_valid, in_ready;
   logic [15:0] out;
   logic        zr, ng, out_valid, out_ready;

   int checks;
   int errors;

   alu16_pipe dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y),
      .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
      .in_valid(in_valid), .in_ready(in_ready),
      .out(out), .zr(zr), .ng(ng),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b,
                        input logic [5:0] c, input logic v);
      x = a;
      y = b;
      {zx, nx, zy, ny, f, no} = c;
      in_valid = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(16'h0, 16'h0, 6'b000000, 1'b0);
      out_ready = 1'b1;
      #12;
      checks++;
      if (out_valid !== 1'b0 || out !== 16'h0000 || zr !== 1'b0 || ng !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got v=%b out=%h zr=%b ng=%b want v=0 out=0000 zr=0 ng=0",
                  out_valid, out, zr, ng);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_ops();
      logic [15:0] tx [8] = '{16'h0005, 16'h0003, 16'hFFFF, 16'h1357,
                              16'h0F0F, 16'h0F00, 16'h2222, 16'h1234};
      logic [15:0] ty [8] = '{16'h0003, 16'h0005, 16'h0001, 16'h9ABC,
                              16'h00FF, 16'h00F0, 16'h3333, 16'h5555};
      logic [5:0]  tc [8] = '{6'b000010, 6'b010011, 6'b000010, 6'b101010,
                              6'b000000, 6'b010101, 6'b111010, 6'b001101};
      logic [15:0] te [8] = '{16'h0008, 16'hFFFE, 16'h0000, 16'h0000,
                              16'h000F, 16'h0FF0, 16'hFFFF, 16'hEDCB};
      logic        tz [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        tn [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(tx[i], ty[i], tc[i], 1'b1);
         step();
         drive(16'hDEAD, 16'hBEEF, 6'b111111, 1'b0);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL op%0d_latency_early: out_valid=%b want 0", i, out_valid);
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out !== te[i] || zr !== tz[i] || ng !== tn[i]) begin
            errors++;
            $display("FAIL op%0d_result: got v=%b out=%h zr=%b ng=%b want v=1 out=%h zr=%b ng=%b",
                     i, out_valid, out, zr, ng, te[i], tz[i], tn[i]);
         end
         step();
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      drive(16'd1, 16'd1, 6'b000010, 1'b1);
      step();
      drive(16'd2, 16'd2, 6'b000010, 1'b1);
      step();
      drive(16'd3, 16'd3, 6'b000010, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 16'h0002
             || zr !== 1'b0 || ng !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: got rdy=%b v=%b out=%h want rdy=0 v=1 out=0002",
                     i, in_ready, out_valid, out);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out !== 16'h0002) begin
         errors++;
         $display("FAIL stall_release: got rdy=%b out=%h want rdy=1 out=0002", in_ready, out);
      end
      step();
      drive(16'h0, 16'h0, 6'b000000, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out !== 16'h0004) begin
         errors++;
         $display("FAIL stall_drain1: got v=%b out=%h want v=1 out=0004", out_valid, out);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out !== 16'h0006) begin
         errors++;
         $display("FAIL stall_drain2: got v=%b out=%h want v=1 out=0006", out_valid, out);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_empty: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      out_ready = 1'b1;
      for (int it = 0; it < 11; it++) begin
         exp = 16'((it - 2) * 8 + 3);
         checks++;
         if (it >= 2 && it < 10) begin
            if (out_valid !== 1'b1 || out !== exp) begin
               errors++;
               $display("FAIL b2b_result%0d: got v=%b out=%h want v=1 out=%h",
                        it - 2, out_valid, out, exp);
            end
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle%0d: out_valid=%b want 0", it, out_valid);
         end
         if (it < 8) drive(16'(it * 3 + 1), 16'(it * 5 + 2), 6'b000010, 1'b1);
         else drive(16'h0, 16'h0, 6'b000000, 1'b0);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready%0d: in_ready=%b want 1", it, in_ready);
         end
         step();
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(16'h0010, 16'h0020, 6'b000010, 1'b1);
      step();
      drive(16'h0030, 16'h0040, 6'b000010, 1'b1);
      step();
      drive(16'h0, 16'h0, 6'b000000, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out !== 16'h0000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: got v=%b out=%h rdy=%b want v=0 out=0000 rdy=1",
                  out_valid, out, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_stale%0d: out_valid=%b want 0", i, out_valid);
         end
      end
      drive(16'h0007, 16'h0009, 6'b000010, 1'b1);
      step();
      drive(16'h0, 16'h0, 6'b000000, 1'b0);
      step();
      checks++;
      if (out_valid !== 1'b1 || out !== 16'h0010) begin
         errors++;
         $display("FAIL post_reset_new: got v=%b out=%h want v=1 out=0010", out_valid, out);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_ops();
      test_stall();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
